// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT engine.
// Holds the default transform size, the engine opcode map, the vec_alu
// operation encodings and the state type used by the address sequencer.
// No ports: this is a package imported by the engine blocks.
package ntt_pkg;

  // Default transform size; N must always equal 2**N_LOG.
  localparam int N_LOG_DEF = 12;
  localparam int N_DEF     = 4096;

  // Engine-level instruction opcodes.
  typedef enum logic [7:0] {
    OP_LOAD   = 8'h02,
    OP_STORE  = 8'h03,
    OP_LOAD_W = 8'h04,
    OP_CONFIG = 8'h05,
    OP_NTT    = 8'h10,
    OP_INTT   = 8'h11,
    OP_ADD    = 8'h20,
    OP_SUB    = 8'h21,
    OP_MULT   = 8'h22
  } engineOp_e;

  // Operation select for the combinational vec_alu.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MULT = 3'b010
  } aluOp_e;

  // Address sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } aguState_e;

endpackage

// File: rtl/ntt_agu.sv
// Address-generation sequencer for an in-place radix-2 Cooley-Tukey NTT/INTT.
// One butterfly per valid cycle: N_LOG stages of N/2 butterflies, no bubbles.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - launch a full transform (only honoured in IDLE)
//   addr_u  - first butterfly operand index
//   addr_v  - second operand index, addr_u + t
//   addr_w  - twiddle index m | i (the engine prefixes the NTT/INTT mode bit)
//   valid   - addr_* describe a butterfly to execute this cycle
//   done    - one-cycle pulse in the cycle after the last valid
module ntt_agu
  import ntt_pkg::*;
#(
  parameter int N_LOG = N_LOG_DEF,
  parameter int N     = N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_LOG-1:0] addr_u,
  output logic [N_LOG-1:0] addr_v,
  output logic [N_LOG-1:0] addr_w,
  output logic             valid,
  output logic             done
);

  localparam int SW = (N_LOG > 1) ? $clog2(N_LOG) : 1;
  localparam int BW = N_LOG - 1;

  localparam logic [SW-1:0]    LAST_S   = SW'(N_LOG - 1);
  localparam logic [BW-1:0]    LAST_B   = BW'(N / 2 - 1);
  localparam logic [N_LOG-1:0] ONE      = N_LOG'(1);
  // First butterfly of stage 0 is (u,v,w) = (0, N/2, 1).
  localparam logic [N_LOG-1:0] LAUNCH_V = ONE << (N_LOG - 1);

  aguState_e        state_q;
  logic [SW-1:0]    stage_q, stage_d;
  logic [BW-1:0]    bfly_q, bfly_d;
  logic [N_LOG-1:0] addrU_q, addrU_d;
  logic [N_LOG-1:0] addrV_q, addrV_d;
  logic [N_LOG-1:0] addrW_q, addrW_d;
  logic             valid_q, done_q;

  logic             lastBfly;
  logic [SW-1:0]    kShift;
  logic [N_LOG-1:0] bExt, tSpan, lowMask, groupIdx;

  // Step (stage, butterfly) to the next position of the RUN walk: b counts
  // up within a stage and wraps to 0 while the stage advances.
  always_comb begin
    lastBfly = (bfly_q == LAST_B);
    stage_d  = stage_q;
    bfly_d   = bfly_q + BW'(1);
    if (lastBfly) begin
      stage_d = stage_q + SW'(1);
      bfly_d  = '0;
    end
  end

  // Addresses of the next butterfly. addr_u is b with a zero spliced in at
  // bit k = N_LOG-1-s, so the pair partner addr_u | t never collides with
  // another butterfly of the same stage.
  always_comb begin
    kShift   = LAST_S - stage_d;
    bExt     = {1'b0, bfly_d};
    tSpan    = ONE << kShift;
    lowMask  = tSpan - ONE;
    groupIdx = bExt >> kShift;
    addrU_d  = ((bExt & ~lowMask) << 1) | (bExt & lowMask);
    addrV_d  = addrU_d | tSpan;
    addrW_d  = (ONE << stage_d) | groupIdx;
  end

  // Sequencer FSM with registered outputs. Addresses are loaded one cycle
  // ahead so the outputs are straight register outputs with no glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      addrU_q <= '0;
      addrV_q <= '0;
      addrW_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            stage_q <= '0;
            bfly_q  <= '0;
            addrU_q <= '0;
            addrV_q <= LAUNCH_V;
            addrW_q <= ONE;
            valid_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (lastBfly && (stage_q == LAST_S)) begin
            state_q <= ST_FIN;
            stage_q <= '0;
            bfly_q  <= '0;
            addrU_q <= '0;
            addrV_q <= '0;
            addrW_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            addrU_q <= addrU_d;
            addrV_q <= addrV_d;
            addrW_q <= addrW_d;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_u = addrU_q;
  assign addr_v = addrV_q;
  assign addr_w = addrW_q;
  assign valid  = valid_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ntt_agu.sv
// Self-checking bench for ntt_agu: an N=8 instance checked against a
// hand-computed butterfly table through an expected-response queue, plus an
// N=4096 instance checked for length, per-stage disjointness and done timing.
module tb_ntt_agu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start12;
  logic [2:0] addr_u, addr_v, addr_w;
  logic       valid, done;
  logic [11:0] u12, v12, w12;
  logic        valid12, done12;

  always #5 clk = ~clk;

  ntt_agu #(.N_LOG(3), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr_u(addr_u), .addr_v(addr_v), .addr_w(addr_w),
    .valid(valid), .done(done)
  );

  ntt_agu #(.N_LOG(12), .N(4096)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12),
    .addr_u(u12), .addr_v(v12), .addr_w(w12),
    .valid(valid12), .done(done12)
  );

  typedef struct {
    bit isDone;
    int u;
    int v;
    int w;
  } expItem_t;

  expItem_t expQ[$];

  // Hand-computed N=8 sequence, stages 0..2.
  int tabU[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int tabV[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int tabW[12] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};

  int errors = 0;
  int checks = 0;
  int doneCount = 0;
  int popCount = 0;
  int done12Count = 0;
  int cnt12 = 0;
  int stageErr = 0;
  bit prevValid = 1'b0;
  bit prevValid12 = 1'b0;
  bit used12[4096];

  localparam logic [63:0] Q = 64'h0800000000000001;
  logic [63:0]  mem[8];
  logic [63:0]  twid[8];
  logic [127:0] prod;
  logic [63:0]  wv, a;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue one full N=8 transform: 12 butterflies followed by the done marker.
  task automatic pushTransform();
    expItem_t e;
    for (int i = 0; i < 12; i++) begin
      e.isDone = 1'b0; e.u = tabU[i]; e.v = tabV[i]; e.w = tabW[i];
      expQ.push_back(e);
    end
    e.isDone = 1'b1; e.u = 0; e.v = 0; e.w = 0;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit toggleDuringRun);
    pushTransform();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (toggleDuringRun) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic waitDone(input int target, input int budget, input bit big, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if ((big ? done12Count : doneCount) >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 64'(valid), 64'd0);
    checkOutput({tag, "_done"},  64'(done),  64'd0);
    checkOutput({tag, "_u"},     64'(addr_u), 64'd0);
    checkOutput({tag, "_v"},     64'(addr_v), 64'd0);
    checkOutput({tag, "_w"},     64'(addr_w), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) twid[i] = 64'(i) * 64'd3 + 64'd5;
  end

  // N=8 monitor: pops the expected queue whenever the DUT shows valid or done
  // and runs the bench butterfly model on its own memory.
  always @(negedge clk) begin
    expItem_t e;
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (valid || done) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpectedOutput: valid=%0b done=%0b with nothing expected", valid, done);
        end else begin
          e = expQ.pop_front();
          checkOutput("doneFlag",  64'(done),  64'(e.isDone));
          checkOutput("validFlag", 64'(valid), 64'(!e.isDone));
          if (!e.isDone && valid) begin
            if (!prevValid) begin
              for (int i = 0; i < 8; i++) mem[i] = 64'd0;
              mem[0] = 64'd1;
            end
            checkOutput("addr_u", 64'(addr_u), 64'(e.u));
            checkOutput("addr_v", 64'(addr_v), 64'(e.v));
            checkOutput("addr_w", 64'(addr_w), 64'(e.w));
            popCount++;
            prod = {64'd0, twid[addr_w]} * {64'd0, mem[addr_v]};
            prod = prod % {64'd0, Q};
            wv = prod[63:0];
            a  = mem[addr_u];
            mem[addr_u] = (a + wv) % Q;
            mem[addr_v] = (a + Q - wv) % Q;
          end
          if (e.isDone && done) begin
            doneCount++;
            checkOutput("doneAfterLastValid", 64'(prevValid), 64'd1);
            for (int i = 0; i < 8; i++) checkOutput("nttOutput", mem[i], 64'd1);
          end
        end
      end
      prevValid = valid;
    end
  end

  // N=4096 monitor: counts butterflies, checks each stage touches every
  // index exactly once with v = u + t, and that done follows the last valid.
  always @(negedge clk) begin
    int stg, idx, t;
    if (!rst_n) begin
      cnt12 = 0;
      prevValid12 = 1'b0;
      stageErr = 0;
    end else begin
      if (valid12) begin
        stg = cnt12 / 2048;
        idx = cnt12 % 2048;
        if (idx == 0) begin
          for (int i = 0; i < 4096; i++) used12[i] = 1'b0;
        end
        t = 2048 >> stg;
        if (used12[u12] || used12[v12] || (int'(v12) != int'(u12) + t)) stageErr++;
        used12[u12] = 1'b1;
        used12[v12] = 1'b1;
        cnt12++;
        if (idx == 2047) begin
          checkOutput("stageDisjoint12", 64'(stageErr), 64'd0);
          stageErr = 0;
        end
      end
      if (done12) begin
        done12Count++;
        checkOutput("done12Valid", 64'(valid12), 64'd0);
        checkOutput("done12AfterLast", 64'(prevValid12), 64'd1);
        checkOutput("validCount12", 64'(cnt12), 64'd24576);
      end
      prevValid12 = valid12;
    end
  end

  initial begin
    int target;
    rst_n = 1'b1;
    start = 1'b0;
    start12 = 1'b0;

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    checkOutput("reset12_valid", 64'(valid12), 64'd0);
    checkOutput("reset12_done",  64'(done12),  64'd0);
    checkOutput("reset12_u",     64'(u12),     64'd0);
    #9 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkAllZero("idle");

    $display("[TB] single transform");
    target = doneCount + 1;
    applyStimulus(1'b0);
    waitDone(target, 100, 1'b0, "waitDone_basic");
    repeat (4) @(posedge clk);

    $display("[TB] start toggled during run");
    target = doneCount + 1;
    applyStimulus(1'b1);
    waitDone(target, 100, 1'b0, "waitDone_toggle");
    repeat (20) @(posedge clk);
    checkOutput("singleDone", 64'(doneCount), 64'(target));
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("[TB] start held high across FIN");
    pushTransform();
    pushTransform();
    target = doneCount + 1;
    @(posedge clk); #1 start = 1'b1;
    waitDone(target, 100, 1'b0, "waitDone_hold1");
    @(posedge clk); #1 start = 1'b0;
    waitDone(target + 1, 100, 1'b0, "waitDone_hold2");
    repeat (20) @(posedge clk);
    checkOutput("holdDoneCount", 64'(doneCount), 64'(target + 1));
    checkOutput("holdQueueDrained", 64'(expQ.size()), 64'd0);

    $display("[TB] reset during run");
    target = popCount + 4;
    pushTransform();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(posedge clk);
        if (popCount >= target) begin ok = 1'b1; break; end
      end
      checkOutput("reachedValid5", 64'(ok), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1 checkAllZero("midReset");
    expQ.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    target = doneCount + 1;
    applyStimulus(1'b0);
    waitDone(target, 100, 1'b0, "waitDone_replay");
    repeat (4) @(posedge clk);
    checkOutput("replayQueueDrained", 64'(expQ.size()), 64'd0);

    $display("[TB] N_LOG=12 transform");
    @(posedge clk); #1 start12 = 1'b1;
    @(posedge clk); #1 start12 = 1'b0;
    waitDone(1, 30000, 1'b1, "waitDone_n12");
    repeat (10) @(posedge clk);
    checkOutput("done12Count", 64'(done12Count), 64'd1);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
